// File: rtl/ccff_chain_loader.sv
// Feeds a configuration chain: buffers one bitstream word at a time and shifts it out MSB-first
// with a per-bit shift enable, while capturing whatever falls out of the chain's tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 160,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] tail_word,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int FW = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     bit_cnt_q;    // bits still to be shifted into the chain
    logic [CW-1:0]     fetch_cnt_q;  // bits still to be pulled from the host
    logic [WORD_W-1:0] shift_q;
    logic [FW-1:0]     fill_q;       // buffered bits not yet placed on ccff_head
    logic              ready_q;
    logic              head_q;
    logic              en_q;
    logic [WORD_W-1:0] tail_q;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     take_d;

    // The final word may contribute fewer than WORD_W bits; its low bits are dropped.
    always_comb begin
        take_d = fetch_cnt_q;
        if (int'(fetch_cnt_q) >= WORD_W) begin
            take_d = CW'(WORD_W);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            fetch_cnt_q <= '0;
            shift_q     <= '0;
            fill_q      <= '0;
            ready_q     <= 1'b0;
            head_q      <= 1'b0;
            en_q        <= 1'b0;
            tail_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_q) begin
                tail_q <= {tail_q[WORD_W-2:0], ccff_tail};
            end
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    en_q    <= 1'b0;
                    if (start) begin
                        state_q     <= S_LOAD;
                        bit_cnt_q   <= CW'(CHAIN_LEN);
                        fetch_cnt_q <= CW'(CHAIN_LEN);
                        fill_q      <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    bit_cnt_q <= bit_cnt_q - CW'(en_q);
                    if (en_q && bit_cnt_q == CW'(1)) begin
                        state_q <= S_DRAIN;
                        en_q    <= 1'b0;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (fill_q != '0) begin
                        head_q  <= shift_q[WORD_W-1];
                        shift_q <= shift_q << 1;
                        fill_q  <= fill_q - FW'(1);
                        en_q    <= 1'b1;
                        // Last buffered bit goes out now, so the next word can land without a bubble.
                        ready_q <= (fill_q == FW'(1)) && (fetch_cnt_q != '0);
                    end else if (cfg_valid && ready_q) begin
                        head_q      <= cfg_data[WORD_W-1];
                        shift_q     <= cfg_data << 1;
                        fill_q      <= FW'(take_d - CW'(1));
                        fetch_cnt_q <= fetch_cnt_q - take_d;
                        en_q        <= 1'b1;
                        ready_q     <= (take_d == CW'(1)) && (fetch_cnt_q != take_d);
                    end else begin
                        en_q    <= 1'b0;
                        ready_q <= (fetch_cnt_q != '0);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    en_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_q;
    assign ccff_head = head_q;
    assign ccff_en   = en_q;
    assign tail_word = tail_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
